// File: rtl/md_unit_pkg.sv
// Shared opcodes, default latencies and opcode predicates for the HI/LO
// multiply/divide unit.
package md_defs;

  localparam logic [3:0] MD_NONE  = 4'b0000;
  localparam logic [3:0] MD_MULT  = 4'b0001;
  localparam logic [3:0] MD_MULTU = 4'b0010;
  localparam logic [3:0] MD_DIV   = 4'b0011;
  localparam logic [3:0] MD_DIVU  = 4'b0100;
  localparam logic [3:0] MD_MTHI  = 4'b0101;
  localparam logic [3:0] MD_MTLO  = 4'b0110;
  localparam logic [3:0] MD_MADD  = 4'b0111;
  localparam logic [3:0] MD_MADDU = 4'b1000;
  localparam logic [3:0] MD_MSUB  = 4'b1001;
  localparam logic [3:0] MD_MSUBU = 4'b1010;

  localparam int MD_MULT_LAT_DFLT = 5;
  localparam int MD_DIV_LAT_DFLT  = 10;

  // Ops that occupy the unit for several cycles and write HI/LO at commit.
  function automatic logic is_md_long(input logic [3:0] op);
    return (op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU,
                       MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU});
  endfunction

  function automatic logic is_md_div(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational datapath: produces the 64-bit {HI,LO} result for a long
// mult/div op and whether it should be written back.
module md_calc
  import md_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        we
);

  logic [63:0] acc;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic        sdiv;
  logic [31:0] div_n;
  logic [31:0] div_d;
  logic [31:0] mag_q;
  logic [31:0] mag_r;
  logic [31:0] quo;
  logic [31:0] rem;

  always_comb begin
    acc    = {hi, lo};
    // Low 64 bits of the product of sign-extended operands equal the signed product.
    prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide runs on magnitudes; INT_MIN / -1 wraps back to INT_MIN.
    sdiv  = (op == MD_DIV);
    div_n = (sdiv && a[31]) ? (32'd0 - a) : a;
    div_d = (sdiv && b[31]) ? (32'd0 - b) : b;
    mag_q = (div_d == 32'd0) ? 32'd0 : (div_n / div_d);
    mag_r = (div_d == 32'd0) ? 32'd0 : (div_n % div_d);
    quo   = (sdiv && (a[31] ^ b[31])) ? (32'd0 - mag_q) : mag_q;
    rem   = (sdiv && a[31]) ? (32'd0 - mag_r) : mag_r;

    result = acc;
    we     = is_md_long(op);
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_MADD:  result = acc + prod_s;
      MD_MADDU: result = acc + prod_u;
      MD_MSUB:  result = acc - prod_s;
      MD_MSUBU: result = acc - prod_u;
      MD_DIV, MD_DIVU: begin
        result = {rem, quo};
        we     = (b != 32'd0);
      end
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the HI/LO registers; Busy covers
// the whole window between an accepted long op and its commit.
module md_unit
  import md_defs::*;
#(
  parameter int MULT_LAT = MD_MULT_LAT_DFLT,
  parameter int DIV_LAT  = MD_DIV_LAT_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MD_CTR,
  input  logic        Start,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   res_q, res_d;
  logic          we_q, we_d;
  logic          busy_q, busy_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;

  logic [63:0]   calc_res;
  logic          calc_we;

  md_calc u_calc (
    .op     (MD_CTR),
    .a      (SrcA),
    .b      (SrcB),
    .hi     (hi_q),
    .lo     (lo_q),
    .result (calc_res),
    .we     (calc_we)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    we_d    = we_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (is_md_long(MD_CTR)) begin
            // HI/LO are frozen while busy, so staging the result now is exact.
            state_d = ST_RUN;
            busy_d  = 1'b1;
            cnt_d   = is_md_div(MD_CTR) ? CW'(DIV_LAT) : CW'(MULT_LAT);
            res_d   = calc_res;
            we_d    = calc_we;
          end else if (MD_CTR == MD_MTHI) begin
            hi_d = SrcA;
          end else if (MD_CTR == MD_MTLO) begin
            lo_d = SrcA;
          end
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cnt_d   = '0;
          if (we_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      res_q   <= '0;
      we_q    <= 1'b0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      we_q    <= we_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: long ops push expected HI/LO and busy length,
// a monitor pops and compares when Busy falls.
module tb_md_unit;
  import md_defs::*;

  logic        clk;
  logic        reset;
  logic [3:0]  MD_CTR;
  logic        Start;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  md_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk    (clk),
    .reset  (reset),
    .MD_CTR (MD_CTR),
    .Start  (Start),
    .SrcA   (SrcA),
    .SrcB   (SrcB),
    .Busy   (Busy),
    .HI     (HI),
    .LO     (LO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end else begin
      $display("ok   %s = 0x%08h", name, act);
    end
  endtask

  // Monitor: counts busy cycles and checks the commit when Busy drops.
  initial begin
    int   busy_cnt;
    logic busy_prev;
    exp_t e;
    busy_cnt  = 0;
    busy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        busy_cnt  = 0;
        busy_prev = 1'b0;
      end else begin
        if (Busy) begin
          busy_cnt++;
        end else if (busy_prev) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_commit actual=commit required=none");
          end else begin
            e = exp_q.pop_front();
            chk({e.name, ".busy_cycles"}, 32'(busy_cnt), 32'(e.lat));
            chk({e.name, ".HI"}, HI, e.hi);
            chk({e.name, ".LO"}, LO, e.lo);
          end
          busy_cnt = 0;
        end
        busy_prev = Busy;
      end
    end
  end

  task automatic pulse(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    MD_CTR = op;
    SrcA   = a;
    SrcB   = b;
    Start  = 1'b1;
    @(posedge clk);
    #1;
    Start  = 1'b0;
    MD_CTR = MD_NONE;
  endtask

  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                       input int lat);
    exp_t e;
    e.name = name;
    e.hi   = ehi;
    e.lo   = elo;
    e.lat  = lat;
    exp_q.push_back(e);
    pulse(op, a, b);
  endtask

  task automatic wait_done(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #2;
      if (!Busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s.timeout actual=still_pending required=committed", name);
      exp_q.delete();
    end
  endtask

  initial begin
    reset  = 1'b1;
    MD_CTR = MD_NONE;
    Start  = 1'b0;
    SrcA   = '0;
    SrcB   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("reset.Busy", 32'(Busy), 32'd0);
    chk("reset.HI", HI, 32'h0);
    chk("reset.LO", LO, 32'h0);

    issue("MULT", MD_MULT, 32'hFFFFFFFF, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFE, 5);
    wait_done("MULT");
    issue("MULTU", MD_MULTU, 32'hFFFFFFFF, 32'h2, 32'h00000001, 32'hFFFFFFFE, 5);
    wait_done("MULTU");
    issue("DIV_neg7_2", MD_DIV, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    wait_done("DIV_neg7_2");

    pulse(MD_MTHI, 32'h11111111, 32'h0);
    chk("MTHI.HI", HI, 32'h11111111);
    chk("MTHI.LO_kept", LO, 32'hFFFFFFFD);
    chk("MTHI.Busy", 32'(Busy), 32'd0);
    pulse(MD_MTLO, 32'h22222222, 32'h0);
    chk("MTLO.LO", LO, 32'h22222222);
    chk("MTLO.HI_kept", HI, 32'h11111111);

    issue("DIVU_by0", MD_DIVU, 32'h12345678, 32'h0, 32'h11111111, 32'h22222222, 10);
    wait_done("DIVU_by0");
    issue("DIV_min_neg1", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
    wait_done("DIV_min_neg1");

    pulse(MD_MTHI, 32'h0, 32'h0);
    pulse(MD_MTLO, 32'hFFFFFFFF, 32'h0);
    issue("MADDU", MD_MADDU, 32'h1, 32'h1, 32'h00000001, 32'h00000000, 5);
    @(posedge clk);
    #1;
    MD_CTR = MD_MULT;
    SrcA   = 32'h5;
    SrcB   = 32'h5;
    Start  = 1'b1;
    @(posedge clk);
    #1;
    Start  = 1'b0;
    MD_CTR = MD_NONE;
    wait_done("MADDU");

    issue("MSUB", MD_MSUB, 32'h2, 32'h3, 32'h00000000, 32'hFFFFFFFA, 5);
    wait_done("MSUB");
    issue("MADD", MD_MADD, 32'hFFFFFFFF, 32'h1, 32'h00000000, 32'hFFFFFFF9, 5);
    wait_done("MADD");
    issue("MSUBU", MD_MSUBU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFF8, 5);
    wait_done("MSUBU");

    pulse(4'b1111, 32'hDEADBEEF, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    chk("noop.Busy", 32'(Busy), 32'd0);
    chk("noop.HI", HI, 32'h00000002);
    chk("noop.LO", LO, 32'hFFFFFFF8);

    pulse(MD_MULT, 32'h3, 32'h3);
    repeat (2) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort.Busy", 32'(Busy), 32'd0);
    chk("abort.HI", HI, 32'h0);
    chk("abort.LO", LO, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("post_abort.Busy", 32'(Busy), 32'd0);
    chk("post_abort.HI", HI, 32'h0);
    chk("post_abort.LO", LO, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Multi-cycle multiply/divide unit for the MIPS execute stage.
- Sits beside the single-cycle ALU and receives the same SrcA/SrcB operands.
- Holds the architectural HI/LO registers and reports Busy so hazard logic can stall MFHI/MFLO/MTHI/MTLO and further mult/div ops.
- Covers MULT, MULTU, DIV, DIVU, MADD, MADDU, MSUB, MSUBU, MTHI and MTLO.

Parameters:
MULT_LAT, 5, busy cycles for MULT/MULTU/MADD/MADDU/MSUB/MSUBU (must be >=1)
DIV_LAT, 10, busy cycles for DIV/DIVU (must be >=1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
MD_CTR  input  4  operation code, valid when Start=1
Start  input  1  single-cycle request from the E stage
SrcA  input  32  operand A (rs)
SrcB  input  32  operand B (rt)
Busy  output  1  multi-cycle op in progress
HI  output  32  HI register, direct from flop
LO  output  32  LO register, direct from flop

Behaviour:
- Reset (async, active-high):
  - Busy=0, HI=0, LO=0, counter=0, staged result cleared.
  - Reset during an operation aborts it; no late write-back occurs.
- MD_CTR codes:
  - 0001 MULT, 0010 MULTU, 0011 DIV, 0100 DIVU
  - 0101 MTHI, 0110 MTLO
  - 0111 MADD, 1000 MADDU, 1001 MSUB, 1010 MSUBU
  - Any other code with Start=1 is a no-op.
- Accept rule: Start is honoured only when Busy=0. Start while Busy=1 is ignored (hazard unit guarantees it never happens; bench checks the ignore).
- MTHI/MTLO (not busy): HI or LO takes SrcA at the same edge. Busy stays 0. The other register is unchanged.
- Mult/div accepted at edge E0:
  - Operands are latched and the 64-bit result is computed into a staged register.
  - Counter is loaded with LAT; Busy=1 from E0 through LAT cycles.
  - At the edge ending the LAT-th busy cycle, HI/LO are written and Busy falls.
  - The new values are visible in the same cycle Busy reads 0.
  - Total Start-to-result latency is LAT+1 edges.
- State machine:
  - IDLE -> RUN on an accepted mult/div Start.
  - RUN: decrement counter; when counter==1, commit and go to IDLE.
  - No back-to-back issue from RUN; a new Start is honoured only in IDLE.
- Arithmetic:
  - MULT: 64-bit product of sign-extended operands. MULTU: zero-extended.
  - MADD(U): {HI,LO} + product. MSUB(U): {HI,LO} - product. Modulo 2^64, signedness per op.
  - The accumulate base is the {HI,LO} value at the commit edge, which equals the value at E0 because HI/LO cannot change while Busy.
  - DIV/DIVU: LO = quotient (truncated toward zero), HI = remainder (sign follows dividend for DIV).
  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0. No trap, no overflow flag.
- Divide by zero (SrcB=0): Busy still asserts for DIV_LAT cycles; HI and LO are left unchanged at commit.
- HI/LO change only on MTHI/MTLO acceptance or a mult/div commit; otherwise they hold.

Decomposition:
- Package md_defs:
  - MD_CTR opcode localparams (MD_NONE, MD_MULT, …, MD_MSUBU)
  - default MULT_LAT/DIV_LAT
  - helper predicate is_md_long(op)
- Sub-module md_calc: purely combinational. Maps op, SrcA, SrcB, HI, LO to a 64-bit result plus a write-enable (deasserted for divide-by-zero).
- md_unit keeps only the FSM, counter, staging register and HI/LO flops.

Test Plan:
- Reset, then MULT SrcA=0xFFFFFFFF SrcB=0x00000002 -> Busy=1 for exactly 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE.
- MULTU with the same operands -> HI=0x00000001 LO=0xFFFFFFFE after 5 busy cycles.
- DIV SrcA=0xFFFFFFF9 (-7) SrcB=2 -> Busy=1 for 10 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF.
- DIVU with HI/LO preloaded via MTHI 0x11111111 / MTLO 0x22222222, SrcB=0 -> Busy asserts 10 cycles, then HI/LO are still 0x11111111/0x22222222. Also DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000 HI=0.
- MTHI 0x0, MTLO 0xFFFFFFFF, then MADDU 1×1 -> HI=0x00000001 LO=0x00000000. A second Start(MULT) issued while Busy is ignored.
- MULT started, then reset asserted asynchronously at busy cycle 3 -> Busy=0 and HI=LO=0 immediately. No write-back after reset release.
